branch_ckpt_ctrl: RTL and testbench
===================================

Name: branch_ckpt_ctrl

Overview:
Manages branch checkpoints and sequences misprediction recovery for the out-of-order core.
- Rename side: allocates a checkpoint slot to each renamed branch, tells the ROB and rename map to snapshot, and stalls rename when no slot is free.
- Resolution side: when the branch unit resolves a branch, the block frees its slot. On a mispredict it drives a one-cycle recover pulse to the ROB, rename map and frontend, then holds a short recovery stall.

Parameters:
NUM_CKPT, 4, number of checkpoint slots (power of two, ≥2).
STALL_CYCLES, 2, rename-stall cycles after the recover pulse (≥1).
ROB_W, ooop_types::ROB_W, ROB tag width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  global flush (exception/trap); clears all state
ren_valid_i  in  1  rename-stage instruction valid; ROB alloc happens the following cycle
ren_is_branch_i  in  1  instruction needs a checkpoint
ren_rob_tag_i  in  ROB_W  ROB tag that instruction will receive
ren_stall_o  out  1  rename must hold
ckpt_take_o  out  1  snapshot request to ROB and rename map
ckpt_tag_o  out  ROB_W  ROB tag for the snapshot
ckpt_id_o  out  $clog2(NUM_CKPT)  slot index allocated
br_valid_i  in  1  branch resolution valid (registered by the BRU)
br_rob_tag_i  in  ROB_W  tag of the resolved branch
br_mispredict_i  in  1  resolution was a mispredict
recover_o  out  1  one-cycle recover pulse to the ROB (recover_i) and the rename map
recover_tag_o  out  ROB_W  tag of the mispredicted branch
recover_ckpt_id_o  out  $clog2(NUM_CKPT)  slot the rename map restores from
redirect_o  out  1  frontend redirect, same cycle as recover_o
ckpt_count_o  out  $clog2(NUM_CKPT)+1  live checkpoint count

Behaviour:
- Reset: synchronous, active-low, applied on rst_n. All slots invalid; head = tail = count = 0; state IDLE.
  - All outputs 0, except ren_stall_o, which is 0 in IDLE with free slots.
- Slot storage: circular queue ordered by allocation (age order). Each slot holds valid, resolved and rob_tag.
- Allocation:
  - acc = ren_valid_i & ren_is_branch_i & !ren_stall_o.
  - On acc: ckpt_take_o = 1 combinationally, ckpt_tag_o = ren_rob_tag_i, ckpt_id_o = tail.
  - Next cycle: slot[tail] = {valid = 1, resolved = 0, tag}; tail advances, count increments.
- ren_stall_o = (count == NUM_CKPT & ren_is_branch_i) | state != IDLE | mis_hit. Non-branches stall only on recovery.
- Resolution match: hit = br_valid_i & a valid, unresolved slot s has tag == br_rob_tag_i. A miss is silently ignored; this covers tags already squashed.
- Correct prediction (hit & !br_mispredict_i): slot s.resolved = 1 next cycle.
- Retirement of slots: each cycle, if slot[head] is valid & resolved, invalidate it, head++, count--. At most one per cycle.
- Mispredict (mis_hit = hit & br_mispredict_i), observed at cycle N:
  - Cycle N (combinational): ren_stall_o = 1. No allocation occurs in cycle N.
  - Cycle N+1 (registered): recover_o = 1, redirect_o = 1, recover_tag_o = tag, recover_ckpt_id_o = s.
  - Slot s is marked resolved. Slots s+1 .. tail-1 are invalidated. tail = s+1. count is recomputed as tail − head, then reduced by a head pop in the same cycle if one occurs.
- State machine:
  - IDLE → REC on mis_hit.
  - REC lasts 1 cycle (the recover pulse) → STALL.
  - STALL counts STALL_CYCLES cycles → IDLE.
  - ren_stall_o stays high from cycle N through the last STALL cycle.
- Older mispredict during REC/STALL: a mis_hit on a still-valid slot is by construction older than the current recovery. It restarts REC next cycle with the new tag/slot and reloads the stall counter.
- Simultaneous events:
  - mis_hit and a head pop in the same cycle: both apply.
  - Correct resolution of slot s and mispredict of an older slot in the same cycle: not possible, single resolution port.
- flush_i: highest priority below reset. Takes effect next cycle: all slots invalid, pointers 0, state IDLE. Suppresses recover_o for that cycle.
- Wrap-around: head and tail are modulo NUM_CKPT. An extra wrap bit distinguishes full from empty.

Decomposition:
- Add ckpt_state_e (IDLE/REC/STALL) and ckpt_slot_t {valid, resolved, rob_tag} to checkpoint_types.
- CKPT_ID_W = $clog2(NUM_CKPT) as a package localparam.
- Sub-module: ckpt_tag_cam. Combinational tag match over slots, returning hit and the one-hot/encoded index.

Test Plan:
1. Reset, then 4 branch renames with tags 3, 4, 5, 6 → ckpt_take_o on each with ckpt_id 0..3; ckpt_count_o = 4; a 5th branch sees ren_stall_o = 1, while a non-branch is not stalled.
2. Resolve tag 4 correct, then tag 3 correct → slot 1 resolved but held; head pops slot 0 and then slot 1 in consecutive cycles; count 4 → 2.
3. Slots with tags 3, 4, 5, 6; mispredict tag 4 at cycle N → cycle N+1: recover_o = 1, recover_tag_o = 4, recover_ckpt_id_o = 1; count = 2; ren_stall_o high for cycles N..N+3; a later resolve of tag 6 is ignored.
4. Mispredict tag 5, then mispredict tag 3 during STALL → a second recover pulse with tag 3; STALL restarts; count = 1.
5. Wrap: allocate and retire 6 branches, then fill 4 slots → ids 2, 3, 0, 1; full is flagged correctly.
6. flush_i asserted with 3 slots live and a mispredict in flight → no recover_o; next cycle count = 0, state IDLE, ren_stall_o = 0.

Source files
------------

// File: rtl/branch_ckpt_ctrl_pkg.sv
// Shared types and defaults for branch checkpoint management and misprediction recovery.
package branch_ckpt_ctrl_pkg;

    localparam int DEF_ROB_W    = 6;
    localparam int DEF_NUM_CKPT = 4;
    localparam int CKPT_ID_W    = $clog2(DEF_NUM_CKPT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        STALL = 2'd2
    } ckpt_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic [DEF_ROB_W-1:0] rob_tag;
    } ckpt_slot_t;

endpackage

// File: rtl/ckpt_tag_cam.sv
// Combinational tag match over the checkpoint slots: only valid, unresolved slots can hit.
module ckpt_tag_cam #(
    parameter int NUM_CKPT = 4,
    parameter int ROB_W    = 6
) (
    input  logic [NUM_CKPT-1:0]            slot_valid,
    input  logic [NUM_CKPT-1:0]            slot_resolved,
    input  logic [NUM_CKPT-1:0][ROB_W-1:0] slot_tag,
    input  logic                           lookup_valid,
    input  logic [ROB_W-1:0]               lookup_tag,
    output logic                           hit,
    output logic [NUM_CKPT-1:0]            hit_oh,
    output logic [$clog2(NUM_CKPT)-1:0]    hit_idx
);
    localparam int IW = $clog2(NUM_CKPT);

    for (genvar i = 0; i < NUM_CKPT; i++) begin : g_match
        assign hit_oh[i] = lookup_valid & slot_valid[i] & ~slot_resolved[i]
                         & (slot_tag[i] == lookup_tag);
    end

    assign hit = |hit_oh;

    // Tags in flight are unique, so at most one bit of hit_oh is set.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_CKPT; i++)
            if (hit_oh[i]) hit_idx = IW'(i);
    end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint allocator and misprediction recovery sequencer (age-ordered circular slot queue).
module branch_ckpt_ctrl
    import branch_ckpt_ctrl_pkg::*;
#(
    parameter int NUM_CKPT     = DEF_NUM_CKPT,
    parameter int STALL_CYCLES = 2,
    parameter int ROB_W        = DEF_ROB_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        ren_valid_i,
    input  logic                        ren_is_branch_i,
    input  logic [ROB_W-1:0]            ren_rob_tag_i,
    output logic                        ren_stall_o,
    output logic                        ckpt_take_o,
    output logic [ROB_W-1:0]            ckpt_tag_o,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id_o,
    input  logic                        br_valid_i,
    input  logic [ROB_W-1:0]            br_rob_tag_i,
    input  logic                        br_mispredict_i,
    output logic                        recover_o,
    output logic [ROB_W-1:0]            recover_tag_o,
    output logic [$clog2(NUM_CKPT)-1:0] recover_ckpt_id_o,
    output logic                        redirect_o,
    output logic [$clog2(NUM_CKPT):0]   ckpt_count_o
);
    localparam int IW = $clog2(NUM_CKPT);
    localparam int PW = IW + 1;
    localparam int SW = $clog2(STALL_CYCLES + 1);

    ckpt_slot_t [NUM_CKPT-1:0]            slots;
    logic       [PW-1:0]                  head, tail, count;
    logic       [IW-1:0]                  head_idx, tail_idx, hit_idx, hit_age;
    logic       [NUM_CKPT-1:0]            slot_valid, slot_resolved, hit_oh;
    logic       [NUM_CKPT-1:0][ROB_W-1:0] slot_tag;
    logic                                 hit, mis_hit, acc, pop, full;
    ckpt_state_e                          state, state_nxt;
    logic       [SW-1:0]                  stall_cnt, stall_cnt_nxt;
    logic       [ROB_W-1:0]               rec_tag;
    logic       [IW-1:0]                  rec_id;

    for (genvar i = 0; i < NUM_CKPT; i++) begin : g_slot
        assign slot_valid[i]    = slots[i].valid;
        assign slot_resolved[i] = slots[i].resolved;
        assign slot_tag[i]      = slots[i].rob_tag;
    end

    ckpt_tag_cam #(.NUM_CKPT(NUM_CKPT), .ROB_W(ROB_W)) u_cam (
        .slot_valid   (slot_valid),
        .slot_resolved(slot_resolved),
        .slot_tag     (slot_tag),
        .lookup_valid (br_valid_i),
        .lookup_tag   (br_rob_tag_i),
        .hit          (hit),
        .hit_oh       (hit_oh),
        .hit_idx      (hit_idx)
    );

    // Extra wrap bit on the pointers makes tail - head the live count (0..NUM_CKPT).
    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign count    = tail - head;
    assign full     = (count == PW'(NUM_CKPT));
    assign hit_age  = hit_idx - head_idx;
    assign mis_hit  = hit & br_mispredict_i;
    assign pop      = slots[head_idx].valid & slots[head_idx].resolved;

    assign ren_stall_o  = (full & ren_is_branch_i) | (state != IDLE) | mis_hit;
    assign acc          = ren_valid_i & ren_is_branch_i & ~ren_stall_o;
    assign ckpt_take_o  = acc;
    assign ckpt_tag_o   = acc ? ren_rob_tag_i : '0;
    assign ckpt_id_o    = acc ? tail_idx : '0;
    assign ckpt_count_o = count;

    assign recover_o         = (state == REC) & ~flush_i;
    assign redirect_o        = recover_o;
    assign recover_tag_o     = recover_o ? rec_tag : '0;
    assign recover_ckpt_id_o = recover_o ? rec_id : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            slots <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            for (int i = 0; i < NUM_CKPT; i++)
                if (hit_oh[i]) slots[i].resolved <= 1'b1;
            if (mis_hit) begin
                // Everything younger than the mispredicted branch is squashed.
                for (int i = 0; i < NUM_CKPT; i++)
                    if (IW'(IW'(i) - head_idx) > hit_age) slots[i].valid <= 1'b0;
                tail <= head + PW'(hit_age) + PW'(1);
            end else if (acc) begin
                slots[tail_idx] <= '{valid: 1'b1, resolved: 1'b0, rob_tag: ren_rob_tag_i};
                tail            <= tail + PW'(1);
            end
            if (pop) begin
                slots[head_idx].valid <= 1'b0;
                head                  <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stall_cnt <= '0;
            rec_tag   <= '0;
            rec_id    <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (mis_hit) begin
                rec_tag <= br_rob_tag_i;
                rec_id  <= hit_idx;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        unique case (state)
            REC: begin
                state_nxt     = STALL;
                stall_cnt_nxt = SW'(STALL_CYCLES - 1);
            end
            STALL: begin
                if (stall_cnt == '0) state_nxt = IDLE;
                else                 stall_cnt_nxt = stall_cnt - SW'(1);
            end
            default: ;
        endcase
        // An older mispredict restarts recovery; flush overrides everything.
        if (mis_hit) state_nxt = REC;
        if (flush_i) state_nxt = IDLE;
    end

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Directed self-checking bench for branch_ckpt_ctrl: allocation, retirement, recovery, wrap and flush.
module tb_branch_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic       ren_valid_i, ren_is_branch_i;
    logic [5:0] ren_rob_tag_i;
    logic       ren_stall_o, ckpt_take_o;
    logic [5:0] ckpt_tag_o;
    logic [1:0] ckpt_id_o;
    logic       br_valid_i, br_mispredict_i;
    logic [5:0] br_rob_tag_i;
    logic       recover_o, redirect_o;
    logic [5:0] recover_tag_o;
    logic [1:0] recover_ckpt_id_o;
    logic [2:0] ckpt_count_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_ckpt_ctrl #(.NUM_CKPT(4), .STALL_CYCLES(2), .ROB_W(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .ren_valid_i      (ren_valid_i),
        .ren_is_branch_i  (ren_is_branch_i),
        .ren_rob_tag_i    (ren_rob_tag_i),
        .ren_stall_o      (ren_stall_o),
        .ckpt_take_o      (ckpt_take_o),
        .ckpt_tag_o       (ckpt_tag_o),
        .ckpt_id_o        (ckpt_id_o),
        .br_valid_i       (br_valid_i),
        .br_rob_tag_i     (br_rob_tag_i),
        .br_mispredict_i  (br_mispredict_i),
        .recover_o        (recover_o),
        .recover_tag_o    (recover_tag_o),
        .recover_ckpt_id_o(recover_ckpt_id_o),
        .redirect_o       (redirect_o),
        .ckpt_count_o     (ckpt_count_o)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 0; ren_valid_i = 0; ren_is_branch_i = 0; ren_rob_tag_i = '0;
        br_valid_i = 0; br_mispredict_i = 0; br_rob_tag_i = '0;
    endtask

    task automatic clear_br();
        br_valid_i = 0; br_mispredict_i = 0; br_rob_tag_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic alloc(input logic [5:0] tag, input logic [1:0] exp_id);
        ren_valid_i = 1; ren_is_branch_i = 1; ren_rob_tag_i = tag;
        #1;
        chk("alloc_take", ckpt_take_o, 1);
        chk("alloc_id", ckpt_id_o, exp_id);
        chk("alloc_tag", ckpt_tag_o, tag);
        tick();
        ren_valid_i = 0; ren_is_branch_i = 0; ren_rob_tag_i = '0;
    endtask

    task automatic set_br(input logic [5:0] tag, input logic mis);
        br_valid_i = 1; br_rob_tag_i = tag; br_mispredict_i = mis;
    endtask

    initial begin
        // Reset state, sampled while reset is held
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        chk("rst_count", ckpt_count_o, 0);
        chk("rst_stall", ren_stall_o, 0);
        chk("rst_recover", recover_o, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_take", ckpt_take_o, 0);
        rst_n = 1;
        tick();

        // 1: fill all four slots, then full stalls branches only
        alloc(6'd3, 2'd0);
        alloc(6'd4, 2'd1);
        alloc(6'd5, 2'd2);
        alloc(6'd6, 2'd3);
        #1;
        chk("t1_count_full", ckpt_count_o, 4);
        ren_valid_i = 1; ren_is_branch_i = 1; ren_rob_tag_i = 6'd7;
        #1;
        chk("t1_full_branch_stall", ren_stall_o, 1);
        chk("t1_full_no_take", ckpt_take_o, 0);
        ren_is_branch_i = 0;
        #1;
        chk("t1_nonbranch_no_stall", ren_stall_o, 0);
        ren_valid_i = 0;
        tick();

        // 2: younger resolves first and is held; then in-order pops
        set_br(6'd4, 0);
        tick();
        clear_br();
        chk("t2_held_count", ckpt_count_o, 4);
        set_br(6'd3, 0);
        tick();
        clear_br();
        chk("t2_count_before_pop", ckpt_count_o, 4);
        tick();
        chk("t2_count_pop1", ckpt_count_o, 3);
        tick();
        chk("t2_count_pop2", ckpt_count_o, 2);
        tick();
        chk("t2_count_steady", ckpt_count_o, 2);

        // 3: mispredict tag 4 (slot 1)
        do_reset();
        alloc(6'd3, 2'd0);
        alloc(6'd4, 2'd1);
        alloc(6'd5, 2'd2);
        alloc(6'd6, 2'd3);
        set_br(6'd4, 1);
        ren_valid_i = 1; ren_is_branch_i = 1; ren_rob_tag_i = 6'd9;
        #1;
        chk("t3_stall_N", ren_stall_o, 1);
        chk("t3_no_take_N", ckpt_take_o, 0);
        tick();
        clear_inputs();
        chk("t3_recover", recover_o, 1);
        chk("t3_redirect", redirect_o, 1);
        chk("t3_recover_tag", recover_tag_o, 4);
        chk("t3_recover_id", recover_ckpt_id_o, 1);
        chk("t3_count", ckpt_count_o, 2);
        chk("t3_stall_N1", ren_stall_o, 1);
        tick();
        chk("t3_pulse_done", recover_o, 0);
        chk("t3_stall_N2", ren_stall_o, 1);
        set_br(6'd6, 1);
        tick();
        clear_br();
        chk("t3_squashed_ignored", recover_o, 0);
        chk("t3_stall_N3", ren_stall_o, 1);
        chk("t3_count_after", ckpt_count_o, 2);
        tick();
        chk("t3_stall_released", ren_stall_o, 0);
        chk("t3_count_final", ckpt_count_o, 2);

        // 4: mispredict tag 5, then older tag 3 during STALL
        do_reset();
        alloc(6'd3, 2'd0);
        alloc(6'd4, 2'd1);
        alloc(6'd5, 2'd2);
        alloc(6'd6, 2'd3);
        set_br(6'd5, 1);
        tick();
        clear_br();
        chk("t4_rec1", recover_o, 1);
        chk("t4_rec1_tag", recover_tag_o, 5);
        chk("t4_rec1_id", recover_ckpt_id_o, 2);
        chk("t4_rec1_count", ckpt_count_o, 3);
        tick();
        set_br(6'd3, 1);
        #1;
        chk("t4_stall_M", ren_stall_o, 1);
        tick();
        clear_br();
        chk("t4_rec2", recover_o, 1);
        chk("t4_rec2_tag", recover_tag_o, 3);
        chk("t4_rec2_id", recover_ckpt_id_o, 0);
        chk("t4_rec2_count", ckpt_count_o, 1);
        tick();
        chk("t4_stall_a", ren_stall_o, 1);
        chk("t4_count_popped", ckpt_count_o, 0);
        tick();
        chk("t4_stall_b", ren_stall_o, 1);
        tick();
        chk("t4_stall_released", ren_stall_o, 0);

        // 5: wrap-around
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(6'(10 + i), 2'(i % 4));
            set_br(6'(10 + i), 0);
            tick();
            clear_br();
            tick();
        end
        chk("t5_empty", ckpt_count_o, 0);
        alloc(6'd20, 2'd2);
        alloc(6'd21, 2'd3);
        alloc(6'd22, 2'd0);
        alloc(6'd23, 2'd1);
        chk("t5_count_full", ckpt_count_o, 4);
        ren_valid_i = 1; ren_is_branch_i = 1;
        #1;
        chk("t5_full_stall", ren_stall_o, 1);
        clear_inputs();

        // 6: flush with a mispredict in flight
        do_reset();
        alloc(6'd3, 2'd0);
        alloc(6'd4, 2'd1);
        alloc(6'd5, 2'd2);
        set_br(6'd4, 1);
        flush_i = 1;
        tick();
        clear_inputs();
        ren_is_branch_i = 1;
        #1;
        chk("t6_no_recover", recover_o, 0);
        chk("t6_no_redirect", redirect_o, 0);
        chk("t6_count", ckpt_count_o, 0);
        chk("t6_stall", ren_stall_o, 0);
        ren_is_branch_i = 0;
        tick();
        chk("t6_still_no_recover", recover_o, 0);
        alloc(6'd7, 2'd0);
        chk("t6_count_realloc", ckpt_count_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
